// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> atan2 angle (Q3.29) and gain-compensated magnitude (Q2.30).
// One micro-rotation per clock; done pulses ITERS+2 edges after capture; requests while busy are dropped.
module cordic_vectoring #(
    parameter int WIDTH = 32,
    parameter int ITERS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] angle_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             busy,
    output logic             done
);
    localparam int DW = WIDTH + 2;
    localparam int PW = 2 * DW;
    localparam int IW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, PREROT, ITER, SCALE} state_t;
    state_t state, state_next;

    // Constants are written as 32-bit fixed point and rescaled to the WIDTH-bit fraction.
    function automatic logic signed [DW-1:0] rescale(input logic [31:0] v);
        return DW'($signed({v, 32'h0}) >>> (64 - WIDTH));
    endfunction

    function automatic logic [31:0] atan_q29(input logic [IW-1:0] k);
        int n;
        n = int'(k);
        case (n)
            0:       return 32'h1921FB54;
            1:       return 32'h0ED63383;
            2:       return 32'h07D6DD7E;
            3:       return 32'h03FAB753;
            4:       return 32'h01FF55BB;
            5:       return 32'h00FFEAAE;
            6:       return 32'h007FFD55;
            7:       return 32'h003FFFAB;
            8:       return 32'h001FFFF5;
            9:       return 32'h000FFFFF;
            default: return 32'd1 << (29 - n);
        endcase
    endfunction

    localparam logic signed [DW-1:0] HALF_PI = rescale(32'h3243F6A9);
    localparam logic signed [DW-1:0] KINV    = rescale(32'h26DD3B6A);

    logic signed [DW-1:0] x, y, z;
    logic signed [DW-1:0] x_sh, y_sh, atan_i;
    logic [IW-1:0]        i;
    logic                 is_zero;

    assign x_sh   = x >>> i;
    assign y_sh   = y >>> i;
    assign atan_i = rescale(atan_q29(i));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_in) state_next = PREROT;
            PREROT:  state_next = ITER;
            ITER:    if (i == IW'(ITERS - 1)) state_next = SCALE;
            SCALE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            is_zero   <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        x       <= DW'($signed(x_in));
                        y       <= DW'($signed(y_in));
                        is_zero <= (x_in == '0) && (y_in == '0);
                        busy    <= 1'b1;
                    end
                end
                PREROT: begin
                    i <= '0;
                    // Fold the left half-plane onto x >= 0 so the iterations only cover +/-pi/2.
                    if (x[DW-1] && !y[DW-1]) begin
                        x <= y;
                        y <= -x;
                        z <= HALF_PI;
                    end else if (x[DW-1]) begin
                        x <= -y;
                        y <= x;
                        z <= -HALF_PI;
                    end else begin
                        z <= '0;
                    end
                end
                ITER: begin
                    i <= i + IW'(1);
                    if (y[DW-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_i;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_i;
                    end
                end
                SCALE: begin
                    // A zero vector would otherwise leave the iteration's accumulated angle in z.
                    mag_out   <= is_zero ? '0 : WIDTH'((PW'(x) * PW'(KINV)) >>> (WIDTH - 2));
                    angle_out <= is_zero ? '0 : z[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed plus randomized checks of cordic_vectoring against an ideal atan2/sqrt reference.
module tb_cordic_vectoring;
    localparam int     WIDTH = 32;
    localparam int     ITERS = 30;
    localparam longint TOL   = 8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] x_in     = '0;
    logic [31:0] y_in     = '0;
    logic [31:0] angle_out;
    logic [31:0] mag_out;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    cordic_vectoring #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic longint sv(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint ideal_angle(input logic [31:0] xv, input logic [31:0] yv);
        real a;
        a = $atan2(real'(sv(yv)), real'(sv(xv))) * 536870912.0;
        return longint'(a);
    endfunction

    function automatic longint ideal_mag(input logic [31:0] xv, input logic [31:0] yv);
        real xr, yr;
        xr = real'(sv(xv));
        yr = real'(sv(yv));
        return longint'($sqrt(xr * xr + yr * yr));
    endfunction

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp);
        longint err;
        err = obs - exp;
        if (err < 0) err = -err;
        tests++;
        assert (err <= TOL) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, TOL);
        end
    endtask

    // Call at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                          output int lat, output logic busy1);
        x_in     = xv;
        y_in     = yv;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat   = 0;
        busy1 = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) busy1 = busy;
        end while (done !== 1'b1 && lat < 100);
    endtask

    task automatic op_and_check(input string tag, input logic [31:0] xv, input logic [31:0] yv);
        int   lat;
        logic b1;
        run_op(xv, yv, lat, b1);
        check_eq({tag, "_latency"}, lat, 32);
        check_near({tag, "_angle"}, sv(angle_out), ideal_angle(xv, yv));
        check_near({tag, "_mag"}, longint'(mag_out), ideal_mag(xv, yv));
    endtask

    initial begin
        int   lat;
        logic b1;
        int   cnt;
        int   xs, ys;
        real  r2;

        // Reset and idle
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_angle", longint'(angle_out), 0);
        check_eq("rst_mag", longint'(mag_out), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check_eq("idle_quiet", cnt, 0);

        // Positive x axis, with latency and handshake details
        run_op(32'h40000000, 32'h0, lat, b1);
        check_eq("axis_latency", lat, 32);
        check_eq("axis_busy_during", longint'(b1), 1);
        check_eq("axis_busy_at_done", longint'(busy), 0);
        check_near("axis_angle", sv(angle_out), 0);
        check_near("axis_mag", longint'(mag_out), 64'h40000000);

        // Back-to-back request on the edge after done
        run_op(32'h0, 32'h40000000, lat, b1);
        check_eq("b2b_latency", lat, 32);
        check_near("yaxis_angle", sv(angle_out), sv(32'h3243F6A9));
        check_near("yaxis_mag", longint'(mag_out), 64'h40000000);

        @(negedge clk);
        check_eq("done_one_cycle", longint'(done), 0);
        run_op(32'hE0000000, 32'hE0000000, lat, b1);
        check_near("q3_angle", sv(angle_out), sv(32'hB49A0E03));
        check_near("q3_mag", longint'(mag_out), 64'h2D413CCD);

        run_op(32'hC0000000, 32'h0, lat, b1);
        check_near("negx_angle", sv(angle_out), sv(32'h6487ED51));
        check_near("negx_mag", longint'(mag_out), 64'h40000000);

        // Zero vector
        run_op(32'h0, 32'h0, lat, b1);
        check_eq("zero_latency", lat, 32);
        check_eq("zero_angle", longint'(angle_out), 0);
        check_eq("zero_mag", longint'(mag_out), 0);

        // A request while busy is ignored
        @(negedge clk);
        x_in = 32'h30000000;
        y_in = 32'h10000000;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(negedge clk);
        x_in = 32'hC0000000;
        y_in = 32'h0;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        cnt = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check_eq("busy_ignore_done_count", cnt, 1);
        check_near("busy_ignore_angle", sv(angle_out), ideal_angle(32'h30000000, 32'h10000000));
        check_near("busy_ignore_mag", longint'(mag_out), ideal_mag(32'h30000000, 32'h10000000));

        // Reset in the middle of iteration 10
        x_in = 32'h20000000;
        y_in = 32'h35000000;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("midop_busy_before_rst", longint'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midop_rst_angle", longint'(angle_out), 0);
        check_eq("midop_rst_mag", longint'(mag_out), 0);
        check_eq("midop_rst_busy", longint'(busy), 0);
        check_eq("midop_rst_done", longint'(done), 0);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check_eq("midop_no_done", cnt, 0);

        run_op(32'h2D413CCD, 32'h2D413CCD, lat, b1);
        check_eq("deg45_latency", lat, 32);
        check_near("deg45_angle", sv(angle_out), sv(32'h1921FB54));
        check_near("deg45_mag", longint'(mag_out), 64'h40000000);

        // Random vectors of magnitude at least 0.5 inside the unit box
        for (int k = 0; k < 12; k++) begin
            do begin
                xs = int'($urandom_range(32'h7FFFFFFF, 0)) - 32'sh40000000;
                ys = int'($urandom_range(32'h7FFFFFFF, 0)) - 32'sh40000000;
                r2 = (real'(xs) * real'(xs) + real'(ys) * real'(ys)) / 1152921504606846976.0;
            end while (r2 < 0.25);
            op_and_check($sformatf("rand%0d", k), 32'(xs), 32'(ys));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
